// File: rtl/axi_mcast_wb_fork_join.sv
// Multicast write fork/join for one crossbar slave port.
// AW select masks are queued twice: the W side forks each beat to every selected
// master port, and the B side joins the per-port responses into one merged B.

package axi_mcast_wb_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } mc_w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [1:0] user;
    } mc_b_chan_t;
endpackage

// Select-mask queue. Occupancy is a register, so full/empty never depend on
// same-cycle push/pop and a pushed entry shows up at the head one cycle later.
module axi_mcast_wb_mask_fifo #(
    parameter int unsigned Width = 4,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wp, rp;
    logic [PtrW:0]    cnt;

    // Pointer and occupancy bookkeeping; callers never push when full or pop when empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_i) wp <= wp + 1'b1;
            if (pop_i)  rp <= rp + 1'b1;
            cnt <= cnt + {{PtrW{1'b0}}, push_i} - {{PtrW{1'b0}}, pop_i};
        end
    end

    // Storage needs no reset: nothing is read while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wp] <= data_i;
    end

    assign head_o  = mem[rp];
    assign empty_o = (cnt == '0);
    assign full_o  = (cnt == (PtrW+1)'(Depth));
endmodule

module axi_mcast_wb_fork_join #(
    parameter int unsigned NoMstPorts = 4,
    parameter int unsigned MaxTrans   = 8,
    parameter type w_chan_t = axi_mcast_wb_pkg::mc_w_chan_t,
    parameter type b_chan_t = axi_mcast_wb_pkg::mc_b_chan_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NoMstPorts-1:0]      aw_select_i,
    input  logic                       aw_valid_i,
    output logic                       aw_ready_o,
    input  w_chan_t                    slv_w_i,
    input  logic                       slv_w_valid_i,
    output logic                       slv_w_ready_o,
    output w_chan_t                    mst_w_o,
    output logic [NoMstPorts-1:0]      mst_w_valid_o,
    input  logic [NoMstPorts-1:0]      mst_w_ready_i,
    input  b_chan_t [NoMstPorts-1:0]   mst_b_i,
    input  logic [NoMstPorts-1:0]      mst_b_valid_i,
    output logic [NoMstPorts-1:0]      mst_b_ready_o,
    output b_chan_t                    slv_b_o,
    output logic                       slv_b_valid_o,
    input  logic                       slv_b_ready_i
);
    localparam int N = int'(NoMstPorts);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    logic [N-1:0] wq_head, bq_head;
    logic         wq_empty, wq_full, bq_empty, bq_full;
    logic         aw_push, w_retire, wq_pop, bq_pop;

    // Held low during reset so no AW is taken while state is being cleared.
    assign aw_ready_o = !rst_i && !wq_full && !bq_full;
    assign aw_push    = aw_valid_i && aw_ready_o;

    axi_mcast_wb_mask_fifo #(.Width(NoMstPorts), .Depth(MaxTrans)) u_wq (
        .clk_i, .rst_i, .push_i(aw_push), .data_i(aw_select_i), .pop_i(wq_pop),
        .head_o(wq_head), .empty_o(wq_empty), .full_o(wq_full)
    );

    axi_mcast_wb_mask_fifo #(.Width(NoMstPorts), .Depth(MaxTrans)) u_bq (
        .clk_i, .rst_i, .push_i(aw_push), .data_i(aw_select_i), .pop_i(bq_pop),
        .head_o(bq_head), .empty_o(bq_empty), .full_o(bq_full)
    );

    // ---------------- W fork ----------------
    logic [N-1:0] w_sent, w_done;

    assign mst_w_o       = slv_w_i;
    assign mst_w_valid_o = {N{!wq_empty && slv_w_valid_i}} & wq_head & ~w_sent;
    assign w_done        = ~wq_head | w_sent | mst_w_ready_i;
    assign slv_w_ready_o = !wq_empty && (&w_done);
    assign w_retire      = slv_w_valid_i && slv_w_ready_o;
    assign wq_pop        = w_retire && slv_w_i.last;

    // Remember which ports already took the current beat so none sees it twice.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         w_sent <= '0;
        else if (w_retire) w_sent <= '0;
        else               w_sent <= w_sent | (mst_w_valid_o & mst_w_ready_i);
    end

    // ---------------- B join ----------------
    logic [N-1:0] b_got, b_hs, b_got_nxt;
    logic         acc_dec, acc_slv, acc_nexo;
    logic         dec_nxt, slv_nxt, nexo_nxt, lo_found, join_done;
    b_chan_t      slv_b_q, slv_b_nxt;
    logic         slv_b_vld;

    assign mst_b_ready_o = {N{!bq_empty && !slv_b_vld}} & bq_head & ~b_got;
    assign b_hs          = mst_b_valid_i & mst_b_ready_o;
    assign b_got_nxt     = b_got | b_hs;
    assign join_done     = !bq_empty && !slv_b_vld && (&(b_got_nxt | ~bq_head));
    assign bq_pop        = slv_b_vld && slv_b_ready_i;
    assign slv_b_o       = slv_b_q;
    assign slv_b_valid_o = slv_b_vld;

    // Fold accepted responses into error flags; lowest selected port donates id/user.
    always_comb begin
        dec_nxt   = acc_dec;
        slv_nxt   = acc_slv;
        nexo_nxt  = acc_nexo;
        slv_b_nxt = slv_b_q;
        lo_found  = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (b_hs[j]) begin
                dec_nxt  = dec_nxt  | (mst_b_i[j].resp == RespDecErr);
                slv_nxt  = slv_nxt  | (mst_b_i[j].resp == RespSlvErr);
                nexo_nxt = nexo_nxt | (mst_b_i[j].resp != RespExOkay);
            end
            if (bq_head[j] && !lo_found) begin
                lo_found = 1'b1;
                if (b_hs[j]) slv_b_nxt = mst_b_i[j];
            end
        end
        // An empty mask reached no slave at all, so it answers as a decode error.
        if (join_done) begin
            if (bq_head == '0 || dec_nxt) slv_b_nxt.resp = RespDecErr;
            else if (slv_nxt)             slv_b_nxt.resp = RespSlvErr;
            else if (nexo_nxt)            slv_b_nxt.resp = RespOkay;
            else                          slv_b_nxt.resp = RespExOkay;
        end
    end

    // Join state; the merged B is registered and frozen until the slave takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_got     <= '0;
            acc_dec   <= 1'b0;
            acc_slv   <= 1'b0;
            acc_nexo  <= 1'b0;
            slv_b_q   <= '0;
            slv_b_vld <= 1'b0;
        end else if (bq_pop) begin
            b_got     <= '0;
            acc_dec   <= 1'b0;
            acc_slv   <= 1'b0;
            acc_nexo  <= 1'b0;
            slv_b_q   <= '0;
            slv_b_vld <= 1'b0;
        end else begin
            b_got    <= b_got_nxt;
            acc_dec  <= dec_nxt;
            acc_slv  <= slv_nxt;
            acc_nexo <= nexo_nxt;
            slv_b_q  <= slv_b_nxt;
            if (join_done) slv_b_vld <= 1'b1;
        end
    end

    // A B from a port the head transaction never addressed is a protocol error.
    b_from_unselected_port: assert property (@(posedge clk_i) disable iff (rst_i)
        !bq_empty |-> ((mst_b_valid_i & ~bq_head) == '0));
endmodule
